// File: rtl/ahb_master_ctrl_if.sv
// Command/response and AHB bus bundle for ahb_master_ctrl.
// Combinational only: no latency and no storage.
// Backpressure is carried by cmd_ready on the command side and by hready on the bus side.
interface ahb_master_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [2:0] cmd_addr;
    logic [2:0] cmd_size;
    logic [7:0] cmd_wdata;

    logic       rsp_valid;
    logic       rsp_write;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       halted;
    logic       err_clear;

    logic       hsel_x;
    logic [1:0] htrans;
    logic [2:0] haddr;
    logic       hwrite;
    logic [2:0] hsize;
    logic [7:0] hwdata;
    logic       hready;
    logic       hresp;
    logic [7:0] hrdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, err_clear,
        input  hready, hresp, hrdata,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err, halted,
        output hsel_x, htrans, haddr, hwrite, hsize, hwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, err_clear,
        output hready, hresp, hrdata,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err, halted,
        input  hsel_x, htrans, haddr, hwrite, hsize, hwdata
    );
endinterface

// File: rtl/ahb_master_ctrl.sv
// Pipelined single-transfer AHB manager fed by a command FIFO; optional hready watchdog under AHB_MASTER_TIMEOUT_EN.
// Latency: push to rsp_valid is 3 cycles minimum, one transfer per cycle sustained with zero wait states.
// Backpressure: cmd_ready drops when the FIFO is full; bus phases stall on hready=0; issue stops in HALT.
module ahb_master_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic              hclk,
    input logic              hreset,
    ahb_master_ctrl_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    typedef struct packed {
        logic       write;
        logic [2:0] addr;
        logic [2:0] size;
        logic [7:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t state, state_nxt;

    cmd_t        fifo_mem [FIFO_DEPTH];
    cmd_t        cmd_in;
    cmd_t        head;
    logic [PW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full;
    logic        push, pop;

    // address-phase registers
    logic       ap_nonseq, hsel_r, hwrite_r;
    logic [2:0] haddr_r, hsize_r;
    logic [7:0] ap_wdata;

    // data-phase registers
    logic       dp_vld, dp_write;
    logic [7:0] hwdata_r;

    logic       rsp_valid_r, rsp_write_r, rsp_err_r;
    logic [7:0] rsp_rdata_r;

    logic completion, busy_nxt, halted_c, timeout;

    assign cmd_in     = {bus.cmd_write, bus.cmd_addr, bus.cmd_size, bus.cmd_wdata};
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head       = fifo_mem[rd_ptr[PW-1:0]];
    assign push       = bus.cmd_valid && !fifo_full;
    assign completion = dp_vld && bus.hready;

    always_ff @(posedge hclk) begin
        if (push) begin
            fifo_mem[wr_ptr[PW-1:0]] <= cmd_in;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

`ifdef AHB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            to_cnt <= '0;
        end else if (!dp_vld || bus.hready || timeout) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // fires on the TIMEOUT_CYCLES-th consecutive stalled data-phase cycle
    assign timeout = dp_vld && !bus.hready && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            ap_nonseq <= 1'b0;
            hsel_r    <= 1'b0;
            haddr_r   <= '0;
            hwrite_r  <= 1'b0;
            hsize_r   <= '0;
            ap_wdata  <= '0;
        end else if (timeout) begin
            ap_nonseq <= 1'b0;
            hsel_r    <= 1'b0;
        end else if (bus.hready) begin
            if (pop) begin
                ap_nonseq <= 1'b1;
                hsel_r    <= 1'b1;
                haddr_r   <= head.addr;
                hwrite_r  <= head.write;
                hsize_r   <= head.size;
                ap_wdata  <= head.wdata;
            end else begin
                ap_nonseq <= 1'b0;
                hsel_r    <= 1'b0;
            end
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            dp_vld   <= 1'b0;
            dp_write <= 1'b0;
            hwdata_r <= '0;
        end else if (timeout) begin
            dp_vld   <= 1'b0;
            dp_write <= 1'b0;
            hwdata_r <= '0;
        end else if (bus.hready) begin
            dp_vld   <= ap_nonseq;
            dp_write <= ap_nonseq && hwrite_r;
            hwdata_r <= (ap_nonseq && hwrite_r) ? ap_wdata : 8'h00;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            rsp_valid_r <= 1'b0;
            rsp_write_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= '0;
        end else begin
            rsp_valid_r <= completion || timeout;
            rsp_write_r <= (completion || timeout) && dp_write;
            rsp_err_r   <= timeout || (completion && bus.hresp);
            rsp_rdata_r <= (completion && !dp_write) ? bus.hrdata : 8'h00;
        end
    end

    // something is still on the bus after this edge
    assign busy_nxt = bus.hready ? (pop || ap_nonseq) : (ap_nonseq || dp_vld);

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (pop) state_nxt = ST_BUSY;
            ST_BUSY: begin
                if (timeout || (completion && bus.hresp)) state_nxt = ST_HALT;
                else if (!busy_nxt)                        state_nxt = ST_IDLE;
            end
            ST_HALT: if (bus.err_clear && !dp_vld && !ap_nonseq) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        halted_c = (state == ST_HALT);
        pop      = bus.hready && !fifo_empty && (state != ST_HALT);
    end

    assign bus.cmd_ready = !fifo_full;
    assign bus.halted    = halted_c;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_write = rsp_write_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.hsel_x    = hsel_r;
    assign bus.htrans    = {ap_nonseq, 1'b0};
    assign bus.haddr     = haddr_r;
    assign bus.hwrite    = hwrite_r;
    assign bus.hsize     = hsize_r;
    assign bus.hwdata    = hwdata_r;
endmodule
